// File: rtl/eq_gain_ctrl_pkg.sv
// Shared types and constants for the 3-band equalizer gain controller.
package eq_ctrl_pkg;

  localparam int GAIN_W    = 3;
  localparam int NUM_BANDS = 3;
  localparam int RPT_CNT_W = 24;

  typedef logic [GAIN_W-1:0] gain_t;
  typedef logic [1:0]        band_t;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  localparam gain_t GAIN_MAX = gain_t'((1 << GAIN_W) - 1);

endpackage

// File: rtl/eq_gain_ctrl_key_repeat.sv
// Edge detect plus auto-repeat for one held key; emits a 1-cycle step pulse
// on the press edge, after REPEAT_DELAY cycles of holding, then every REPEAT_RATE cycles.
module key_repeat
  import eq_ctrl_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 5_000_000,
  parameter int unsigned REPEAT_RATE  = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic step
);

  localparam logic [RPT_CNT_W-1:0] DELAY_LAST = RPT_CNT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_CNT_W-1:0] RATE_LAST  = RPT_CNT_W'(REPEAT_RATE - 1);

  rpt_state_t             state, state_next;
  logic [RPT_CNT_W-1:0]   cnt, cnt_next;
  logic                   key_prev;
  logic                   key_edge;

  // History resets high so a key held through reset gives no edge until re-pressed.
  assign key_edge = key & ~key_prev;

  // State, counter and key history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RPT_IDLE;
      cnt      <= '0;
      key_prev <= 1'b1;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      key_prev <= key;
    end
  end

  // Next-state, counter and step pulse; releasing the key always returns to idle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    step       = 1'b0;
    case (state)
      RPT_IDLE: begin
        if (key_edge) begin
          state_next = RPT_DELAY;
          cnt_next   = '0;
          step       = 1'b1;
        end
      end
      RPT_DELAY: begin
        if (!key) begin
          state_next = RPT_IDLE;
          cnt_next   = '0;
        end else if (cnt == DELAY_LAST) begin
          state_next = RPT_REPEAT;
          cnt_next   = '0;
          step       = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RPT_REPEAT: begin
        if (!key) begin
          state_next = RPT_IDLE;
          cnt_next   = '0;
        end else if (cnt == RATE_LAST) begin
          cnt_next = '0;
          step     = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = RPT_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/eq_gain_ctrl.sv
// Gain controller for the 3-band equalizer: key edits land in shadow gains and
// are copied to the choose bus only on a sample strobe, so a gain never changes mid-sample.
module eq_gain_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter gain_t       DEFAULT_GAIN = gain_t'(4),
  parameter int unsigned REPEAT_DELAY = 5_000_000,
  parameter int unsigned REPEAT_RATE  = 1_000_000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  btn_band,
  input  logic  btn_up,
  input  logic  btn_down,
  input  logic  btn_flat,
  input  logic  sam_strobe,
  output gain_t choose [NUM_BANDS-1:0],
  output band_t band_sel,
  output logic  update_pend
);

  gain_t shadow      [NUM_BANDS-1:0];
  gain_t shadow_next [NUM_BANDS-1:0];
  band_t band_next;
  logic  edit_changed;
  logic  band_prev, flat_prev;
  logic  band_ev, flat_ev;
  logic  up_step, down_step;

  assign band_ev = btn_band & ~band_prev;
  assign flat_ev = btn_flat & ~flat_prev;

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_up_repeat (
    .clk  (clk),
    .rst  (rst),
    .key  (btn_up),
    .step (up_step)
  );

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_down_repeat (
    .clk  (clk),
    .rst  (rst),
    .key  (btn_down),
    .step (down_step)
  );

  // One action per cycle, flat over band over up/down; up and down together cancel out.
  always_comb begin
    shadow_next  = shadow;
    band_next    = band_sel;
    edit_changed = 1'b0;
    if (flat_ev) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        if (shadow[i] != DEFAULT_GAIN) edit_changed = 1'b1;
        shadow_next[i] = DEFAULT_GAIN;
      end
    end else if (band_ev) begin
      band_next = (band_sel == band_t'(NUM_BANDS - 1)) ? '0 : band_sel + band_t'(1);
    end else if (!(btn_up && btn_down)) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        if (band_sel == band_t'(i)) begin
          if (up_step && shadow[i] != GAIN_MAX) begin
            shadow_next[i] = shadow[i] + gain_t'(1);
            edit_changed   = 1'b1;
          end else if (down_step && shadow[i] != '0) begin
            shadow_next[i] = shadow[i] - gain_t'(1);
            edit_changed   = 1'b1;
          end
        end
      end
    end
  end

  // Commit copies the pre-edit shadow; an edit in the commit cycle keeps the update pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        choose[i] <= DEFAULT_GAIN;
        shadow[i] <= DEFAULT_GAIN;
      end
      band_sel    <= '0;
      update_pend <= 1'b0;
      band_prev   <= 1'b1;
      flat_prev   <= 1'b1;
    end else begin
      band_prev <= btn_band;
      flat_prev <= btn_flat;
      band_sel  <= band_next;
      shadow    <= shadow_next;
      if (sam_strobe && update_pend) choose <= shadow;
      update_pend <= edit_changed | (update_pend & ~sam_strobe);
    end
  end

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Scoreboard bench for eq_gain_ctrl with short repeat timing (delay 8, rate 4).
module tb_eq_gain_ctrl;
  import eq_ctrl_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  btn_band, btn_up, btn_down, btn_flat, sam_strobe;
  gain_t choose [NUM_BANDS-1:0];
  band_t band_sel;
  logic  update_pend;

  typedef struct {
    string tag;
    gain_t c0, c1, c2;
    band_t bs;
    logic  pend;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   steps [7] = '{0, 8, 12, 16, 20, 24, 28};

  always #5 clk = ~clk;

  eq_gain_ctrl #(
    .DEFAULT_GAIN (gain_t'(4)),
    .REPEAT_DELAY (8),
    .REPEAT_RATE  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_band    (btn_band),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_flat    (btn_flat),
    .sam_strobe  (sam_strobe),
    .choose      (choose),
    .band_sel    (band_sel),
    .update_pend (update_pend)
  );

  // Drive one cycle of inputs, then return just after the edge that sampled them.
  task automatic applyStimulus(input int up, input int down, input int band,
                               input int flat, input int strobe);
    btn_up     = (up != 0);
    btn_down   = (down != 0);
    btn_band   = (band != 0);
    btn_flat   = (flat != 0);
    sam_strobe = (strobe != 0);
    @(posedge clk);
    #1;
  endtask

  // Queue the state the DUT must show after the edge just taken.
  task automatic checkOutput(input string tag, input int c0, input int c1, input int c2,
                             input int bs, input int pend);
    exp_t e;
    e.tag  = tag;
    e.c0   = gain_t'(c0);
    e.c1   = gain_t'(c1);
    e.c2   = gain_t'(c2);
    e.bs   = band_t'(bs);
    e.pend = (pend != 0);
    sb.push_back(e);
  endtask

  // Monitor: on the falling edge pop every queued expectation and compare.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (choose[0] === mon_e.c0 && choose[1] === mon_e.c1 && choose[2] === mon_e.c2 &&
          band_sel === mon_e.bs && update_pend === mon_e.pend)
        n_pass++;
      else
        $display("[TB] FAIL %s: got choose=%0d/%0d/%0d band_sel=%0d update_pend=%0b, expected choose=%0d/%0d/%0d band_sel=%0d update_pend=%0b",
                 mon_e.tag, choose[0], choose[1], choose[2], band_sel, update_pend,
                 mon_e.c0, mon_e.c1, mon_e.c2, mon_e.bs, mon_e.pend);
    end
  end

  // Watchdog in case the stimulus stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got no end of stimulus, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Main stimulus sequence following the specification's test list.
  initial begin
    int n, cur, nxt, pend;
    rst = 1'b1;
    btn_band = 0; btn_up = 0; btn_down = 0; btn_flat = 0; sam_strobe = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 4, 4, 4, 0, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);

    // Three up presses on band 0, no strobe: choose holds, pending set.
    for (int p = 1; p <= 3; p++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput($sformatf("up_press%0d", p), 4, 4, 4, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("commit_up", 7, 4, 4, 0, 0);

    // Band wraps 0->1->2->0.
    for (int p = 1; p <= 3; p++) begin
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput($sformatf("band_press%0d", p), 7, 4, 4, p % 3, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end

    // Flat back to 4, then six downs on band 0 with a commit after each.
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("flat_pend", 7, 4, 4, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("flat_commit", 4, 4, 4, 0, 0);
    for (int p = 1; p <= 6; p++) begin
      cur = (p <= 5) ? 5 - p : 0;
      nxt = (p <= 4) ? 4 - p : 0;
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput($sformatf("down_press%0d", p), cur, 4, 4, 0, (p <= 4) ? 1 : 0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput($sformatf("down_commit%0d", p), nxt, 4, 4, 0, 0);
    end

    // Band 1 down to 0 ahead of the hold run.
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("band_to_1", 0, 4, 4, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int p = 1; p <= 4; p++) begin
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("band1_zero", 0, 0, 4, 1, 0);

    // Hold up 30 cycles with a strobe every cycle: choose[1] trails shadow by one cycle.
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1, 0, 0, 0, 1);
      n = 0;
      pend = 0;
      foreach (steps[j]) begin
        if (steps[j] < k) n++;
        if (steps[j] == k) pend = 1;
      end
      checkOutput($sformatf("hold_k%0d", k), 0, n, 4, 1, pend);
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput($sformatf("released_k%0d", k), 0, 7, 4, 1, 0);
    end

    // Up edge in the same cycle as a commit on band 2.
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("band_to_2", 0, 7, 4, 2, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("b2_up", 0, 7, 4, 2, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("b2_down", 0, 7, 4, 2, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("strobe_plus_up", 0, 7, 4, 2, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("late_commit", 0, 7, 5, 2, 0);

    // Flat beats up; up and down together do nothing.
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("flat_plus_up", 0, 7, 5, 2, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("flat_plus_up_commit", 4, 4, 4, 2, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("up_plus_down", 4, 4, 4, 2, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("up_plus_down_strobe", 4, 4, 4, 2, 0);

    // Reset with up held and an edit pending; held key must not step after release.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("pend_before_reset", 4, 4, 4, 2, 1);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_held", 4, 4, 4, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput($sformatf("held_after_reset_k%0d", k), 4, 4, 4, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("release_after_reset", 4, 4, 4, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("repress_after_reset", 4, 4, 4, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("repress_commit", 5, 4, 4, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("repress_idle", 5, 4, 4, 0, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0)
      $display("[TB] FAIL scoreboard: got %0d unchecked expectations, expected 0", sb.size());
    if (n_checks < 12)
      $display("[TB] FAIL check count: got %0d checks, expected at least 12", n_checks);
    if (n_pass == n_checks && n_checks >= 12 && sb.size() == 0)
      $display("[TB] PASS %0d/%0d checks passed", n_pass, n_checks);
    else
      $display("[TB] FAIL %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
